// File: rtl/block_lock_67_if.sv
// ============================================================================
// block_lock_67_if : 67-bit gearbox word in, 64-bit decoded word out
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface block_lock_67_if;
  logic [66:0] din;
  logic        din_valid;
  logic [63:0] dout;
  logic        dout_ctrl;
  logic        dout_err;
  logic        dout_valid;
  logic        slip;
  logic        locked;

  modport master (
    output din, din_valid,
    input  dout, dout_ctrl, dout_err, dout_valid, slip, locked
  );

  modport slave (
    input  din, din_valid,
    output dout, dout_ctrl, dout_err, dout_valid, slip, locked
  );
endinterface

`default_nettype wire

// File: rtl/block_lock_67.sv
// ============================================================================
// block_lock_67 : 64b/67b block lock, header-driven bit slip and de-inversion
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module block_lock_67 #(
  parameter int LOCK_CNT  = 64,
  parameter int WINDOW    = 64,
  parameter int ERR_LIMIT = 16,
  parameter int SLIP_WAIT = 4
) (
  input  wire logic      clk,
  input  wire logic      arst,
  block_lock_67_if.slave bus
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam int SW = $clog2(SLIP_WAIT + 1);

  localparam logic [GW-1:0] C_LOCK_CNT  = GW'(LOCK_CNT);
  localparam logic [WW-1:0] C_WINDOW    = WW'(WINDOW);
  localparam logic [EW-1:0] C_ERR_LIMIT = EW'(ERR_LIMIT);
  localparam logic [SW-1:0] C_SLIP_WAIT = SW'(SLIP_WAIT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e        state_q;
  logic [GW-1:0] good_cnt_q, good_cnt_d;
  logic [WW-1:0] win_cnt_q,  win_cnt_d;
  logic [EW-1:0] err_cnt_q,  err_cnt_d;
  logic [SW-1:0] wait_cnt_q;

  logic [63:0] dout_q;
  logic        dout_ctrl_q;
  logic        dout_err_q;
  logic        dout_valid_q;
  logic        slip_q;
  logic        locked_q;

  logic hdr_good;

  assign hdr_good = bus.din[65] ^ bus.din[64];

  // Candidate counter values for the word currently presented.
  always_comb begin
    good_cnt_d = good_cnt_q + GW'(1);
    win_cnt_d  = win_cnt_q + WW'(1);
    err_cnt_d  = err_cnt_q + EW'(!hdr_good);
  end

  always_ff @(posedge clk) begin
    if (!arst) begin
      state_q      <= ST_HUNT;
      good_cnt_q   <= '0;
      win_cnt_q    <= '0;
      err_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      dout_q       <= '0;
      dout_ctrl_q  <= 1'b0;
      dout_err_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      slip_q       <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      slip_q       <= 1'b0;
      dout_valid_q <= bus.din_valid && (state_q == ST_LOCKED);

      if (bus.din_valid) begin
        dout_q      <= bus.din[66] ? ~bus.din[63:0] : bus.din[63:0];
        dout_ctrl_q <= (bus.din[65:64] == 2'b10);
        dout_err_q  <= !hdr_good;

        case (state_q)
          ST_HUNT: begin
            if (!hdr_good) begin
              slip_q     <= 1'b1;
              good_cnt_q <= '0;
              wait_cnt_q <= C_SLIP_WAIT;
              state_q    <= ST_WAIT;
            end else if (good_cnt_d == C_LOCK_CNT) begin
              good_cnt_q <= '0;
              win_cnt_q  <= '0;
              err_cnt_q  <= '0;
              locked_q   <= 1'b1;
              state_q    <= ST_LOCKED;
            end else begin
              good_cnt_q <= good_cnt_d;
            end
          end

          // Gearbox is still settling from the slip; headers are meaningless.
          ST_WAIT: begin
            if (wait_cnt_q <= SW'(1)) begin
              wait_cnt_q <= '0;
              good_cnt_q <= '0;
              state_q    <= ST_HUNT;
            end else begin
              wait_cnt_q <= wait_cnt_q - SW'(1);
            end
          end

          // Loss of lock wins over the window rollover on the same word.
          ST_LOCKED: begin
            if (err_cnt_d == C_ERR_LIMIT) begin
              locked_q   <= 1'b0;
              slip_q     <= 1'b1;
              wait_cnt_q <= C_SLIP_WAIT;
              win_cnt_q  <= '0;
              err_cnt_q  <= '0;
              state_q    <= ST_WAIT;
            end else if (win_cnt_d == C_WINDOW) begin
              win_cnt_q <= '0;
              err_cnt_q <= '0;
            end else begin
              win_cnt_q <= win_cnt_d;
              err_cnt_q <= err_cnt_d;
            end
          end

          default: begin
            state_q  <= ST_HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_ctrl  = dout_ctrl_q;
  assign bus.dout_err   = dout_err_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.slip       = slip_q;
  assign bus.locked     = locked_q;

endmodule

`default_nettype wire

// File: tb/tb_block_lock_67.sv
// ============================================================================
// tb_block_lock_67 : directed bench with a word-level reference model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_block_lock_67;

  logic clk = 1'b0;
  logic arst;

  always #5 clk = ~clk;

  block_lock_67_if bus ();

  block_lock_67 #(
    .LOCK_CNT  (64),
    .WINDOW    (64),
    .ERR_LIMIT (16),
    .SLIP_WAIT (4)
  ) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  localparam logic [66:0] W_CTRL = {3'b010, 64'h1234567812345678};
  localparam logic [66:0] W_DATA = {3'b001, 64'h0f0f0f0f55aa55aa};
  localparam logic [66:0] W_INV  = {3'b101, 64'h0123456789abcdef};
  localparam logic [66:0] W_BAD  = {3'b000, 64'hdeadbeefcafef00d};
  localparam logic [66:0] W_JUNK = {3'b111, 64'hffffffffffffffff};

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: word-level bookkeeping of the lock rules.
  bit m_locked;
  int m_streak;   // good headers seen in a row while hunting
  int m_settle;   // words still to be ignored after a slip
  int m_win;      // words seen in the current monitoring window
  int m_errs;     // bad headers seen in the current window

  logic [63:0] exp_dout;
  logic        exp_ctrl, exp_err, exp_valid, exp_slip, exp_locked;
  bit          exp_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic model(input logic rstn, input logic v, input logic [66:0] w);
    bit good;
    if (!rstn) begin
      m_locked = 0; m_streak = 0; m_settle = 0; m_win = 0; m_errs = 0;
      exp_dout = '0; exp_ctrl = 0; exp_err = 0; exp_valid = 0; exp_slip = 0;
      exp_data = 1;
    end else begin
      exp_slip  = 0;
      exp_valid = v && m_locked;
      exp_data  = exp_valid;
      if (v) begin
        good     = (w[65] != w[64]);
        exp_dout = w[66] ? ~w[63:0] : w[63:0];
        exp_ctrl = (w[65:64] == 2'b10);
        exp_err  = !good;
        if (m_settle > 0) begin
          m_settle--;
        end else if (!m_locked) begin
          if (good) begin
            m_streak++;
            if (m_streak == 64) begin
              m_locked = 1; m_streak = 0; m_win = 0; m_errs = 0;
            end
          end else begin
            exp_slip = 1; m_streak = 0; m_settle = 4;
          end
        end else begin
          m_win++;
          if (!good) m_errs++;
          if (m_errs == 16) begin
            m_locked = 0; exp_slip = 1; m_settle = 4; m_win = 0; m_errs = 0;
          end else if (m_win == 64) begin
            m_win = 0; m_errs = 0;
          end
        end
      end
    end
    exp_locked = m_locked;
  endtask

  // One clock: drive at the falling edge, check just after the rising edge.
  task automatic cycle(input logic rstn, input logic v, input logic [66:0] w);
    @(negedge clk);
    arst          = rstn;
    bus.din_valid = v;
    bus.din       = w;
    model(rstn, v, w);
    @(posedge clk);
    #1;
    chk("locked", {63'd0, bus.locked}, {63'd0, exp_locked});
    chk("slip", {63'd0, bus.slip}, {63'd0, exp_slip});
    chk("dout_valid", {63'd0, bus.dout_valid}, {63'd0, exp_valid});
    if (exp_data) begin
      chk("dout", bus.dout, exp_dout);
      chk("dout_ctrl", {63'd0, bus.dout_ctrl}, {63'd0, exp_ctrl});
      chk("dout_err", {63'd0, bus.dout_err}, {63'd0, exp_err});
    end
  endtask

  initial begin
    arst          = 1'b0;
    bus.din       = '0;
    bus.din_valid = 1'b0;

    // Reset while garbage streams in
    repeat (3) cycle(1'b0, 1'b1, W_JUNK);
    chk("rst_locked", {63'd0, bus.locked}, 64'd0);
    chk("rst_dout", bus.dout, 64'd0);
    cycle(1'b1, 1'b0, '0);
    chk("idle_no_slip", {63'd0, bus.slip}, 64'd0);

    // Acquire lock with idle gaps interleaved
    for (int i = 0; i < 64; i++) begin
      if (i % 16 == 7) cycle(1'b1, 1'b0, W_BAD);
      cycle(1'b1, 1'b1, W_CTRL);
      if (i == 62) chk("lock_not_yet", {63'd0, bus.locked}, 64'd0);
    end
    chk("lock_after_64", {63'd0, bus.locked}, 64'd1);

    cycle(1'b1, 1'b1, W_CTRL);
    chk("first_dout", bus.dout, 64'h1234567812345678);
    chk("first_ctrl", {63'd0, bus.dout_ctrl}, 64'd1);
    chk("first_valid", {63'd0, bus.dout_valid}, 64'd1);

    cycle(1'b1, 1'b1, W_INV);
    chk("inv_dout", bus.dout, 64'hfedcba9876543210);
    chk("inv_ctrl", {63'd0, bus.dout_ctrl}, 64'd0);

    // 15 errors in a window are tolerated; window is 2 words in already
    repeat (15) cycle(1'b1, 1'b1, W_BAD);
    repeat (47) cycle(1'b1, 1'b1, W_DATA);
    chk("15err_hold", {63'd0, bus.locked}, 64'd1);

    // 16 errors in the fresh window drop lock
    repeat (15) cycle(1'b1, 1'b1, W_BAD);
    chk("15err_again", {63'd0, bus.locked}, 64'd1);
    cycle(1'b1, 1'b1, W_BAD);
    chk("loss_slip", {63'd0, bus.slip}, 64'd1);
    chk("loss_locked", {63'd0, bus.locked}, 64'd0);

    // Settle period, then slip behaviour while hunting
    repeat (4) begin
      cycle(1'b1, 1'b1, W_BAD);
      chk("settle_no_slip", {63'd0, bus.slip}, 64'd0);
    end
    repeat (10) cycle(1'b1, 1'b1, W_CTRL);
    cycle(1'b1, 1'b1, W_BAD);
    chk("hunt_slip1", {63'd0, bus.slip}, 64'd1);
    repeat (4) begin
      cycle(1'b1, 1'b1, W_BAD);
      chk("wait_no_slip", {63'd0, bus.slip}, 64'd0);
    end
    cycle(1'b1, 1'b1, {3'b011, 64'h0});
    chk("hunt_slip2", {63'd0, bus.slip}, 64'd1);
    repeat (4) cycle(1'b1, 1'b1, W_CTRL);
    repeat (63) cycle(1'b1, 1'b1, W_CTRL);
    chk("relock_not_yet", {63'd0, bus.locked}, 64'd0);
    cycle(1'b1, 1'b1, W_CTRL);
    chk("relock", {63'd0, bus.locked}, 64'd1);

    // 16th error on the window's last word still loses lock
    repeat (48) cycle(1'b1, 1'b1, W_DATA);
    repeat (15) cycle(1'b1, 1'b1, W_BAD);
    chk("edge_hold", {63'd0, bus.locked}, 64'd1);
    cycle(1'b1, 1'b1, W_BAD);
    chk("edge_slip", {63'd0, bus.slip}, 64'd1);
    chk("edge_loss", {63'd0, bus.locked}, 64'd0);

    // Relock, then reset in the middle of lock
    repeat (4) cycle(1'b1, 1'b1, W_DATA);
    repeat (64) cycle(1'b1, 1'b1, W_DATA);
    chk("lock3", {63'd0, bus.locked}, 64'd1);
    cycle(1'b0, 1'b1, W_DATA);
    chk("midrst_locked", {63'd0, bus.locked}, 64'd0);
    chk("midrst_valid", {63'd0, bus.dout_valid}, 64'd0);
    repeat (63) cycle(1'b1, 1'b1, W_DATA);
    chk("post_rst_not_yet", {63'd0, bus.locked}, 64'd0);
    cycle(1'b1, 1'b1, W_DATA);
    chk("post_rst_lock", {63'd0, bus.locked}, 64'd1);
    cycle(1'b1, 1'b1, W_DATA);
    chk("post_rst_valid", {63'd0, bus.dout_valid}, 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
